// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared definitions for the load/store unit.
//            Size encodings, FSM state type, lane mask and alignment helpers.
// Revision : 1.0  initial release
// ============================================================================
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    WR     = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5
  } lsu_state_e;

  // Right-justified all-ones mask covering the access size.
  function automatic logic [63:0] size_mask(input logic [1:0] size);
    logic [63:0] m;
    case (size)
      SZ_B:    m = 64'h0000_0000_0000_00FF;
      SZ_H:    m = 64'h0000_0000_0000_FFFF;
      SZ_W:    m = 64'h0000_0000_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

  // An access is misaligned when the lane offset is not a multiple of its size.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
    logic m;
    case (size)
      SZ_B:    m = 1'b0;
      SZ_H:    m = off[0];
      SZ_W:    m = |off[1:0];
      default: m = |off;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_lane_align
// Purpose  : Combinational lane steering for the LSU.
//            Loads : select lane at byte offset, mask to size, zero/sign extend.
//            Stores: merge right-justified store data into the old doubleword.
// Ports    : i_rdata      old / read doubleword from memory
//            i_wdata      right-justified store data
//            i_size       access size encoding
//            i_off        byte offset within the doubleword
//            i_signed     sign-extend load result
//            o_load_data  extended load result
//            o_merge_data doubleword to write back for a sub-dword store
// Revision : 1.0  initial release
// ============================================================================
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [63:0] i_rdata,
  input  logic [63:0] i_wdata,
  input  logic [1:0]  i_size,
  input  logic [2:0]  i_off,
  input  logic        i_signed,
  output logic [63:0] o_load_data,
  output logic [63:0] o_merge_data
);

  logic [5:0]  w_shamt;
  logic [63:0] w_mask;
  logic [63:0] w_shifted;
  logic        w_sign;

  assign w_shamt   = {i_off, 3'b000};
  assign w_mask    = size_mask(i_size);
  assign w_shifted = i_rdata >> w_shamt;

  // Top bit of the selected lane; a full dword never needs extension.
  always_comb begin
    w_sign = 1'b0;
    case (i_size)
      SZ_B:    w_sign = w_shifted[7];
      SZ_H:    w_sign = w_shifted[15];
      SZ_W:    w_sign = w_shifted[31];
      default: w_sign = 1'b0;
    endcase
  end

  assign o_load_data  = (w_shifted & w_mask) | ((i_signed && w_sign) ? ~w_mask : 64'h0);
  assign o_merge_data = (i_rdata & ~(w_mask << w_shamt)) | ((i_wdata & w_mask) << w_shamt);

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ctrl
// Purpose  : Load/store initiator between execute stage and data memory.
//            One request at a time; sub-dword stores use read-modify-write.
// Ports    : clk, rst_n              clock, synchronous active-low reset
//            req_*                   request handshake and fields
//            resp_valid/rdata/err    single-cycle response
//            mem_addr, MemRead,      memory interface (read data is
//            MemWrite, mem_wdata,    combinational, writes land on the
//            mem_rdata               next rising edge)
// Revision : 1.0  initial release
// ============================================================================
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int MEM_IDX_LSB = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [2:0]        off_q, off_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [63:0]       w_load_data;
  logic [63:0]       w_merge_data;

  // Steering works on latched request fields and the live memory read data.
  lsu_lane_align u_lane_align (
    .i_rdata      (mem_rdata),
    .i_wdata      (wdata_q),
    .i_size       (size_q),
    .i_off        (off_q),
    .i_signed     (signed_q),
    .o_load_data  (w_load_data),
    .o_merge_data (w_merge_data)
  );

  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    size_d       = size_q;
    signed_d     = signed_q;
    off_d        = off_q;
    wdata_d      = wdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          size_d     = req_size;
          signed_d   = req_signed;
          off_d      = req_addr[2:0];
          wdata_d    = req_wdata;
          // Doubleword index placed at MEM_IDX_LSB, low bits zero.
          mem_addr_d = (req_addr >> 3) << MEM_IDX_LSB;
          if (misaligned(req_size, req_addr[2:0])) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (!req_write) begin
            state_d    = RD;
            mem_read_d = 1'b1;
          end else if (req_size == SZ_D) begin
            state_d     = WR;
            mem_write_d = 1'b1;
            mem_wdata_d = req_wdata;
          end else begin
            state_d    = RMW_RD;
            mem_read_d = 1'b1;
          end
        end
      end
      RD: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = w_load_data;
      end
      WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = '0;
      end
      RMW_RD: begin
        state_d     = RMW_WR;
        mem_write_d = 1'b1;
        mem_wdata_d = w_merge_data;
      end
      RMW_WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = '0;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_wdata_q  <= '0;
      size_q       <= SZ_B;
      signed_q     <= 1'b0;
      off_q        <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_wdata_q  <= mem_wdata_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign MemRead    = mem_read_q;
  assign MemWrite   = mem_write_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_ctrl
// Purpose  : Self-checking bench for lsu_ctrl with a dword memory device and
//            a byte-addressed reference memory.
// Revision : 1.0  initial release
// ============================================================================
module tb_lsu_ctrl;

  localparam int IDX_LSB = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [63:0] mem_addr;
  logic        MemRead;
  logic        MemWrite;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_W(64), .DATA_W(64), .MEM_IDX_LSB(IDX_LSB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Memory device: combinational read, write on rising edge.
  logic [63:0] mem [0:1023];
  assign mem_rdata = MemRead ? mem[mem_addr[IDX_LSB+9:IDX_LSB]] : 64'h0;
  always @(posedge clk) if (MemWrite) mem[mem_addr[IDX_LSB+9:IDX_LSB]] <= mem_wdata;

  // Reference: plain byte array, little-endian.
  logic [7:0] ref_b [0:8191];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] ref_dword(input int idx);
    logic [63:0] v = 64'h0;
    for (int i = 0; i < 8; i++) v |= 64'(ref_b[idx*8+i]) << (8*i);
    return v;
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] addr, input logic [1:0] sz, input logic sg);
    int          n = 1 << sz;
    int          a = int'(addr[12:0]);
    logic [63:0] v = 64'h0;
    logic [63:0] m;
    if ((a % n) != 0) return 64'h0;
    for (int i = 0; i < n; i++) v |= 64'(ref_b[a+i]) << (8*i);
    m = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'h1 << (8*n)) - 64'h1);
    if (sg && n < 8 && v[8*n-1]) v |= ~m;
    return v;
  endfunction

  task automatic ref_store(input logic [63:0] addr, input logic [1:0] sz, input logic [63:0] wd);
    int n = 1 << sz;
    int a = int'(addr[12:0]);
    for (int i = 0; i < n; i++) ref_b[a+i] = 8'(wd >> (8*i));
  endtask

  // One complete transaction with latency, strobe, address, data and memory checks.
  task automatic run_req(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [63:0] addr, input logic [63:0] wd,
                         output logic [63:0] rdata_o);
    int          n       = 1 << sz;
    bit          err     = (int'(addr[2:0]) % n) != 0;
    int          exp_lat = err ? 1 : (wr && sz != 2'b11) ? 3 : 2;
    int          exp_nr  = (err || (wr && sz == 2'b11)) ? 0 : 1;
    int          exp_nw  = (err || !wr) ? 0 : 1;
    logic [63:0] exp_rd  = (err || wr) ? 64'h0 : ref_load(addr, sz, sg);
    logic [63:0] exp_ma  = {3'b000, addr[63:3]} << IDX_LSB;
    int          idx     = int'(addr[12:3]);
    int          lat = 0, nr = 0, nw = 0;
    bit          got = 0;
    logic        got_err = 1'b0;
    logic [63:0] got_rd  = 64'h0;

    @(negedge clk);
    chk("req_ready_idle", 64'(req_ready), 64'h1);
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 8 && !got; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (MemRead)  nr++;
      if (MemWrite) nw++;
      if (MemRead || MemWrite) chk("mem_addr", mem_addr, exp_ma);
      chk("strobe_excl", 64'(MemRead & MemWrite), 64'h0);
      if (resp_valid) begin
        got     = 1;
        lat     = c;
        got_err = resp_err;
        got_rd  = resp_rdata;
      end
    end
    chk("resp_seen", 64'(got), 64'h1);
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("resp_err", 64'(got_err), 64'(err));
    chk("resp_rdata", got_rd, exp_rd);
    chk("n_memread", 64'(nr), 64'(exp_nr));
    chk("n_memwrite", 64'(nw), 64'(exp_nw));
    @(posedge clk);
    #1;
    chk("resp_one_cycle", 64'(resp_valid), 64'h0);
    chk("ready_after_resp", 64'(req_ready), 64'h1);
    chk("rdata_hold", resp_rdata, got_rd);
    if (wr && !err) ref_store(addr, sz, wd);
    chk("mem_content", mem[idx], ref_dword(idx));
    rdata_o = got_rd;
  endtask

  initial begin
    logic [63:0] v;
    logic [63:0] r;
    logic [63:0] a;
    logic [1:0]  sz;

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 64'h0;
    req_wdata  = 64'h0;

    for (int i = 0; i < 1024; i++) begin
      v = (i == 8) ? 64'h8877665544332211 : {$urandom, $urandom};
      mem[i] <= v;
      for (int b = 0; b < 8; b++) ref_b[i*8+b] = 8'(v >> (8*b));
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'h1);
    chk("rst_resp_valid", 64'(resp_valid), 64'h0);
    chk("rst_resp_err", 64'(resp_err), 64'h0);
    chk("rst_resp_rdata", resp_rdata, 64'h0);
    chk("rst_memread", 64'(MemRead), 64'h0);
    chk("rst_memwrite", 64'(MemWrite), 64'h0);
    chk("rst_mem_addr", mem_addr, 64'h0);
    chk("rst_mem_wdata", mem_wdata, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_req(1'b0, 2'b00, 1'b0, 64'h43, 64'h0, r);
    chk("tp_ld_byte", r, 64'h44);
    run_req(1'b0, 2'b01, 1'b1, 64'h46, 64'h0, r);
    chk("tp_ld_half_signed", r, 64'hFFFFFFFFFFFF8877);
    run_req(1'b1, 2'b11, 1'b0, 64'h80, 64'hDEADBEEFCAFEF00D, r);
    chk("tp_st_dword_mem", mem[16], 64'hDEADBEEFCAFEF00D);
    run_req(1'b0, 2'b11, 1'b0, 64'h80, 64'h0, r);
    chk("tp_ld_dword_back", r, 64'hDEADBEEFCAFEF00D);
    run_req(1'b1, 2'b00, 1'b0, 64'h45, 64'h00000000000000AB, r);
    chk("tp_rmw_byte_mem", mem[8], 64'h8877AB5544332211);
    run_req(1'b0, 2'b10, 1'b0, 64'h42, 64'h0, r);
    chk("tp_misaligned_rdata", r, 64'h0);

    // Reset during RMW_RD abandons the store
    @(negedge clk);
    req_write  = 1'b1;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 64'h45;
    req_wdata  = 64'h12;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("rmw_rd_memread", 64'(MemRead), 64'h1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst_ready", 64'(req_ready), 64'h1);
    chk("midrst_memwrite", 64'(MemWrite), 64'h0);
    chk("midrst_memread", 64'(MemRead), 64'h0);
    chk("midrst_resp_valid", 64'(resp_valid), 64'h0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("post_rst_no_write", 64'(MemWrite), 64'h0);
      chk("post_rst_no_resp", 64'(resp_valid), 64'h0);
    end
    chk("post_rst_mem", mem[8], ref_dword(8));
    run_req(1'b0, 2'b11, 1'b0, 64'h40, 64'h0, r);
    chk("post_rst_load", r, 64'h8877AB5544332211);

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      sz = 2'($urandom_range(0, 3));
      a  = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a[2:0] = a[2:0] & ~3'((1 << sz) - 1);
      run_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, r);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
